// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: loader state encoding and sizing helper
package ccff_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: holds one bitstream word and presents it MSB first
module ccff_word_serializer import ccff_loader_pkg::*; #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              en,
  input  logic              flush,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              shift_req,
  output logic              msb
);
  localparam int WC_W = clog2(WORD_W + 1);
  logic [WORD_W-1:0] sr;
  logic [WC_W-1:0]   wcnt;
  // flush refuses a word offered alongside an abort
  always_comb begin
    word_ready = en && !flush && wcnt == '0;
    shift_req  = en && wcnt != '0;
    msb        = sr[WORD_W-1];
  end
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) begin
      sr   <= '0;
      wcnt <= '0;
    end else if (!en || flush) wcnt <= '0;
    else if (word_ready && word_valid) begin
      sr   <= word_data;
      wcnt <= WC_W'(WORD_W);
    end else if (shift_req) begin
      sr   <= sr << 1;
      wcnt <= wcnt - WC_W'(1);
    end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises bitstream words into a ccff chain, then
// recirculates the chain once and compares the count of 1s seen at the tail
module ccff_bitstream_loader import ccff_loader_pkg::*; #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              pass
);
  state_t state, state_n;
  logic [CNT_W-1:0] bcnt, hones, tones;
  logic shift_req, msb, last, flush;
  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .en         (state == LOAD),
    .flush      (flush),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .shift_req  (shift_req),
    .msb        (msb)
  );
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = start && !abort ? LOAD : IDLE;
      LOAD:    state_n = abort ? IDLE : shift_en && last ? VERIFY : LOAD;
      VERIFY:  state_n = abort ? IDLE : last ? FINISH : VERIFY;
      default: state_n = IDLE;
    endcase
  end
  // in VERIFY the tail is fed straight back so one revolution preserves the chain
  always_comb begin
    busy      = state != IDLE;
    shift_en  = state == VERIFY || (state == LOAD && shift_req);
    ccff_head = state == VERIFY ? ccff_tail : state == LOAD ? msb : 1'b0;
    last      = bcnt == CNT_W'(1);
    flush     = abort || (shift_en && last);
  end
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) begin
      bcnt  <= '0;
      hones <= '0;
      tones <= '0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if (state == IDLE && start && !abort) begin
      bcnt  <= CNT_W'(CHAIN_LEN);
      hones <= '0;
      tones <= '0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if ((state == LOAD || state == VERIFY) && abort) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (shift_en) begin
      bcnt  <= state == LOAD && last ? CNT_W'(CHAIN_LEN) : bcnt - CNT_W'(1);
      hones <= hones + CNT_W'(state == LOAD && ccff_head);
      tones <= tones + CNT_W'(state == VERIFY && ccff_tail);
    end else if (state == FINISH) begin
      pass <= hones == tones;
      done <= 1'b1;
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: chain model, per-cycle compare, directed runs
module tb_ccff_bitstream_loader;
  localparam int L = 20;
  localparam int W = 8;
  localparam logic [L-1:0] FLIP = L'(1) << 7;
  logic prog_clk = 1'b0, prog_reset = 1'b1;
  always #5 prog_clk = ~prog_clk;
  logic start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [W-1:0] word_data = '0;
  logic word_ready, ccff_head, ccff_tail, shift_en, busy, done, pass;
  logic start_b = 1'b0, word_valid_b = 1'b0;
  logic [W-1:0] word_data_b = '0;
  logic word_ready_b, head_b, tail_b, shift_en_b, busy_b, done_b, pass_b;
  logic [L-1:0] chain = '0, cm, exp_chain;
  logic chain_b = 1'b0;
  logic flip_req = 1'b0, armed = 1'b0;
  logic [W-1:0] words [3] = '{8'hA5, 8'h3C, 8'hF0};
  int checks = 0, failures = 0;
  int ls, vs, hs, widx, gap, lcyc, ncyc, starve_len = 0;

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .shift_en(shift_en),
    .busy(busy), .done(done), .pass(pass));
  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(1)) dut_b (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b), .abort(1'b0),
    .word_data(word_data_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
    .ccff_head(head_b), .ccff_tail(tail_b), .shift_en(shift_en_b),
    .busy(busy_b), .done(done_b), .pass(pass_b));

  // the target chains: first bit shifted in ends up at the tail
  assign ccff_tail = chain[L-1];
  assign tail_b = chain_b;
  assign cm = flip_req ? chain ^ FLIP : chain;
  always @(posedge prog_clk) begin
    chain   <= shift_en ? {cm[L-2:0], ccff_head} : cm;
    chain_b <= shift_en_b ? head_b : chain_b;
  end

  function automatic logic exp_bit(input int i);
    logic [W-1:0] w;
    w = words[i / W];
    return w[W - 1 - i % W];
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  always @(negedge prog_clk)
    if (!armed) begin
      ls <= 0; vs <= 0; hs <= 0; widx <= 0; gap <= 0; lcyc <= 0; ncyc <= 0;
    end else if (!done) begin
      ncyc <= ncyc + 1;
      if (ls < L) lcyc <= lcyc + 1;
      chk("busy", busy, 1);
      chk("ready_excl", shift_en & word_ready, 0);
      chk("shift_budget", 32'(ls + vs > 2 * L), 0);
      if (widx == 1 && gap < starve_len && word_ready) begin
        chk("starve_hold", shift_en, 0);
        gap <= gap + 1;
      end
      if (shift_en && ls < L) begin
        chk("head_bit", ccff_head, exp_bit(ls));
        ls <= ls + 1;
      end else if (shift_en) begin
        chk("recirc", ccff_head, ccff_tail);
        vs <= vs + 1;
      end
      if (word_ready && word_valid) begin
        hs <= hs + 1;
        widx <= widx + 1;
      end
    end

  task automatic run(input int starve, input int abort_at, input int rst_at, input bit flip);
    bit aborted, ended, flipped, reset_hit;
    logic exp_pass;
    aborted = 0; ended = 0; flipped = 0; reset_hit = 0;
    starve_len = starve;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0; armed = 1'b1;
    for (int c = 0; c < 300 && !ended; c++) begin
      flip_req = 1'b0;
      abort = 1'b0;
      if (done) ended = 1;
      else if (aborted) begin
        chk("abort_shift", shift_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        ended = 1;
      end else if (rst_at >= 0 && vs == rst_at) begin
        armed = 1'b0;
        #2 prog_reset = 1'b1;
        #1 chk("rst_outs", {word_ready, ccff_head, shift_en, busy, done, pass}, 0);
        reset_hit = 1;
        ended = 1;
        @(negedge prog_clk) prog_reset = 1'b0;
      end else begin
        word_valid = widx < 3 && !(widx == 1 && gap < starve_len);
        word_data = words[widx < 3 ? widx : 0];
        if (flip && !flipped && ls == L) begin flip_req = 1'b1; flipped = 1; end
        if (abort_at >= 0 && ls == abort_at) begin abort = 1'b1; aborted = 1; end
        @(posedge prog_clk); #1;
      end
    end
    chk("timeout", ended, 1);
    armed = 1'b0;
    word_valid = 1'b0;
    if (aborted) begin
      chk("abort_hs", hs, 2);
      repeat (3) begin
        @(posedge prog_clk); #1;
        chk("abort_idle", {shift_en, word_ready, busy}, 0);
      end
    end else if (!reset_hit) begin
      exp_pass = $countones(chain) == $countones(exp_chain);
      chk("done", done, 1);
      chk("pass_model", pass, exp_pass);
      chk("pass_lit", pass, !flip);
      chk("busy_end", busy, 0);
      chk("handshakes", hs, 3);
      chk("load_shifts", ls, L);
      chk("verify_shifts", vs, L);
      chk("load_cycles", lcyc, 23 + starve);
      chk("run_cycles", ncyc, 44 + starve);
      chk("chain", chain, exp_chain ^ (flip ? FLIP : '0));
      if (!flip) chk("chain_lit", chain, 20'hA53CF);
      repeat (3) @(posedge prog_clk);
      #1 chk("done_held", done, 1);
    end
  endtask

  task automatic run_b(input logic [7:0] w);
    int hsb, nsh, cyc;
    bit fin;
    hsb = 0; nsh = 0; cyc = 0; fin = 0;
    @(posedge prog_clk); #1 start_b = 1'b1; word_data_b = w; word_valid_b = 1'b1;
    @(posedge prog_clk); #1;
    for (int c = 0; c < 20 && !fin; c++) begin
      start_b = c == 1;
      #1;
      if (done_b) fin = 1;
      else begin
        if (word_ready_b && word_valid_b) hsb++;
        if (shift_en_b) begin
          nsh++;
          chk("b_head", head_b, nsh == 1 ? w[7] : tail_b);
        end
        cyc++;
        @(posedge prog_clk); #1;
      end
    end
    start_b = 1'b0;
    word_valid_b = 1'b0;
    chk("b_done", fin, 1);
    chk("b_pass", pass_b, 1);
    chk("b_busy", busy_b, 0);
    chk("b_hs", hsb, 1);
    chk("b_shifts", nsh, 2);
    chk("b_cycles", cyc, 4);
    chk("b_chain", chain_b, w[7]);
  endtask

  initial begin
    for (int i = 0; i < L; i++) exp_chain[L-1-i] = exp_bit(i);
    repeat (2) @(posedge prog_clk);
    #1 chk("reset_outs", {word_ready, ccff_head, shift_en, busy, done, pass}, 0);
    chk("reset_outs_b", {word_ready_b, head_b, shift_en_b, busy_b, done_b, pass_b}, 0);
    @(negedge prog_clk) prog_reset = 1'b0;
    run(0, -1, -1, 0);
    run(5, -1, -1, 0);
    run(0, -1, -1, 1);
    run(0, 9, -1, 0);
    run(0, -1, -1, 0);
    run(0, 16, -1, 0);
    run(0, -1, 5, 0);
    run(0, -1, -1, 0);
    @(posedge prog_clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {busy, shift_en, word_ready}, 0);
    chk("start_abort_done", done, 1);
    run_b(8'h80);
    run_b(8'h7F);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
